// File: rtl/vga_rect_scheduler_if.sv
// Command handshake bundle between the two requesters and vga_rect_scheduler.
interface vga_rect_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [67:0] req0_cmd;
  logic        req1_valid;
  logic        req1_ready;
  logic [67:0] req1_cmd;

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/vga_rect_scheduler.sv
// Round-robin rectangle-overlay command scheduler; commits at vertical-sync start.
// Optional bounds rejection when VGA_RECT_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | no offer outstanding; arbitrate among valid requesters
// OFFER   | ready raised to the granted requester for one cycle
// PENDING | shadow loaded, waiting for the next frame start to commit
module vga_rect_scheduler #(
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter logic [10:0] DEF_X0        = 11'd100,
  parameter logic [10:0] DEF_Y0        = 11'd100,
  parameter logic [10:0] DEF_X1        = 11'd200,
  parameter logic [10:0] DEF_Y1        = 11'd200,
  parameter logic [23:0] DEF_COLOR     = 24'hFF4500
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic                 vs,
  vga_rect_scheduler_if.slave  req,
  output logic [10:0]          rect_x0,
  output logic [10:0]          rect_y0,
  output logic [10:0]          rect_x1,
  output logic [10:0]          rect_y1,
  output logic [23:0]          rect_color,
  output logic                 pending,
  output logic                 commit_pulse,
  output logic                 last_grant,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {IDLE, OFFER, PENDING} state_t;

  localparam logic VS_ON = ~VS_ACTIVE_LOW;

  state_t      state;
  logic        grant;
  logic        vs_q;
  logic [67:0] shadow;

  logic        fs;
  logic        pick;
  logic        g_valid;
  logic [67:0] g_cmd;
  logic        cmd_bad;

  assign fs      = (vs_q != VS_ON) && (vs == VS_ON);
  // Contention goes to whoever was not granted last; otherwise the sole requester.
  assign pick    = (req.req0_valid && req.req1_valid) ? ~last_grant : req.req1_valid;
  assign g_valid = grant ? req.req1_valid : req.req0_valid;
  assign g_cmd   = grant ? req.req1_cmd   : req.req0_cmd;

`ifdef VGA_RECT_CHECK_EN
  assign cmd_bad = (g_cmd[45:35] < g_cmd[67:57]) || (g_cmd[34:24] < g_cmd[56:46]);
`else
  assign cmd_bad = 1'b0;
`endif

  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      vs_q           <= ~VS_ON;
      shadow         <= '0;
      rect_x0        <= DEF_X0;
      rect_y0        <= DEF_Y0;
      rect_x1        <= DEF_X1;
      rect_y1        <= DEF_Y1;
      rect_color     <= DEF_COLOR;
      pending        <= 1'b0;
      commit_pulse   <= 1'b0;
      cmd_err        <= 1'b0;
      req.req0_ready <= 1'b0;
      req.req1_ready <= 1'b0;
    end else begin
      vs_q         <= vs;
      commit_pulse <= 1'b0;
      cmd_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req0_valid || req.req1_valid) begin
            grant          <= pick;
            last_grant     <= pick;
            req.req0_ready <= ~pick;
            req.req1_ready <= pick;
            state          <= OFFER;
          end
        end
        OFFER: begin
          req.req0_ready <= 1'b0;
          req.req1_ready <= 1'b0;
          if (!g_valid) begin
            state <= IDLE;
          end else if (cmd_bad) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            shadow  <= g_cmd;
            pending <= 1'b1;
            state   <= PENDING;
          end
        end
        PENDING: begin
          if (fs) begin
            rect_x0      <= shadow[67:57];
            rect_y0      <= shadow[56:46];
            rect_x1      <= shadow[45:35];
            rect_y1      <= shadow[34:24];
            rect_color   <= shadow[23:0];
            commit_pulse <= 1'b1;
            pending      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Self-checking bench for vga_rect_scheduler with a transaction-level reference model.
module tb_vga_rect_scheduler;
  localparam int F    = 40;
  localparam int SYNC = 4;
  localparam logic [67:0] DEF = {11'd100, 11'd100, 11'd200, 11'd200, 24'hFF4500};

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b0;
  logic        vs      = 1'b1;
  logic [10:0] rect_x0, rect_y0, rect_x1, rect_y1;
  logic [23:0] rect_color;
  logic        pending, commit_pulse, last_grant, cmd_err;

  vga_rect_scheduler_if rif();

  vga_rect_scheduler dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .vs           (vs),
    .req          (rif.slave),
    .rect_x0      (rect_x0),
    .rect_y0      (rect_y0),
    .rect_x1      (rect_x1),
    .rect_y1      (rect_y1),
    .rect_color   (rect_color),
    .pending      (pending),
    .commit_pulse (commit_pulse),
    .last_grant   (last_grant),
    .cmd_err      (cmd_err)
  );

  always #5 vga_clk = ~vga_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          vs_en = 1'b1;
  logic        vsq_m = 1'b1;
  bit          fs_edge = 1'b0;
  logic [67:0] m_rect = DEF;
  logic [67:0] m_shadow = '0;
  logic        m_lg = 1'b1;
  logic [67:0] rect_all;

  assign rect_all = {rect_x0, rect_y0, rect_x1, rect_y1, rect_color};

  // One clock; fs_edge says whether the edge just taken was a frame start.
  task automatic step();
    logic vb, rb;
    vb = vs;
    rb = reset;
    @(posedge vga_clk);
    fs_edge = rb && vsq_m && !vb;
    vsq_m   = rb ? vb : 1'b1;
    #1;
    cyc++;
    vs = vs_en ? ((cyc % F) >= SYNC) : 1'b1;
  endtask

  function automatic logic [67:0] rand_cmd();
    logic [10:0] a, b, c, d, t;
    logic [23:0] col;
    a = 11'($urandom_range(0, 2047));
    b = 11'($urandom_range(0, 2047));
    c = 11'($urandom_range(0, 2047));
    d = 11'($urandom_range(0, 2047));
    col = 24'($urandom);
    if (b < a) begin t = a; a = b; b = t; end
    if (d < c) begin t = c; c = d; d = t; end
    return {a, c, b, d, col};
  endfunction

  task automatic grant_accept(input bit v0, input bit v1, input logic [67:0] c0,
                              input logic [67:0] c1, input bit drop, input bit reject,
                              output bit acc_fs);
    logic w;
    w = (v0 && v1) ? ~m_lg : v1;
    rif.req0_valid = v0; rif.req0_cmd = c0;
    rif.req1_valid = v1; rif.req1_cmd = c1;
    step();
    n_cmp++; if (rif.req0_ready !== ~w) begin n_err++; $display("FAIL offer_ready0: got %b want %b", rif.req0_ready, ~w); end
    n_cmp++; if (rif.req1_ready !== w) begin n_err++; $display("FAIL offer_ready1: got %b want %b", rif.req1_ready, w); end
    n_cmp++; if (last_grant !== w) begin n_err++; $display("FAIL last_grant: got %b want %b", last_grant, w); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL offer_pending: got %b want 0", pending); end
    step();
    acc_fs = fs_edge;
    m_lg = w;
    n_cmp++; if ({rif.req0_ready, rif.req1_ready} !== 2'b00) begin n_err++; $display("FAIL ready_after_accept: got %b want 00", {rif.req0_ready, rif.req1_ready}); end
    n_cmp++; if (commit_pulse !== 1'b0) begin n_err++; $display("FAIL commit_at_accept: got %b want 0", commit_pulse); end
    n_cmp++; if (pending !== ~reject) begin n_err++; $display("FAIL accept_pending: got %b want %b", pending, ~reject); end
    n_cmp++; if (cmd_err !== reject) begin n_err++; $display("FAIL accept_cmd_err: got %b want %b", cmd_err, reject); end
    n_cmp++; if (rect_all !== m_rect) begin n_err++; $display("FAIL rect_before_commit: got %h want %h", rect_all, m_rect); end
    if (!reject) m_shadow = w ? c1 : c0;
    if (drop) begin rif.req0_valid = 1'b0; rif.req1_valid = 1'b0; end
  endtask

  task automatic wait_commit();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3 * F; k++) begin
      step();
      if (fs_edge) begin seen = 1'b1; break; end
      n_cmp++; if (commit_pulse !== 1'b0 || pending !== 1'b1 || rect_all !== m_rect) begin
        n_err++; $display("FAIL hold_pending: pulse %b pending %b rect %h want 0 1 %h", commit_pulse, pending, rect_all, m_rect);
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL fs_timeout: no frame start within %0d cycles", 3 * F); end
    m_rect = m_shadow;
    n_cmp++; if (rect_all !== m_rect) begin n_err++; $display("FAIL commit_rect: got %h want %h", rect_all, m_rect); end
    n_cmp++; if (commit_pulse !== 1'b1) begin n_err++; $display("FAIL commit_pulse: got %b want 1", commit_pulse); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL commit_pending: got %b want 0", pending); end
  endtask

  task automatic test_reset();
    rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
    rif.req0_cmd = '0; rif.req1_cmd = '0;
    reset = 1'b0;
    step(); step();
    n_cmp++; if (rect_all !== DEF) begin n_err++; $display("FAIL reset_rect: got %h want %h", rect_all, DEF); end
    n_cmp++; if ({pending, commit_pulse, cmd_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {pending, commit_pulse, cmd_err}); end
    n_cmp++; if ({rif.req0_ready, rif.req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {rif.req0_ready, rif.req1_ready}); end
    n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_idle_frames();
    for (int k = 0; k < 2 * F; k++) begin
      step();
      n_cmp++; if (commit_pulse !== 1'b0) begin n_err++; $display("FAIL idle_commit: got %b want 0", commit_pulse); end
    end
    n_cmp++; if (rect_all !== DEF || pending !== 1'b0) begin n_err++; $display("FAIL idle_state: rect %h pending %b want %h 0", rect_all, pending, DEF); end
  endtask

  task automatic test_single();
    bit acc;
    for (int k = 0; k < F && (cyc % F) != F / 2; k++) step();
    grant_accept(1'b1, 1'b0, {11'd10, 11'd20, 11'd30, 11'd40, 24'h00FF00}, '0, 1'b1, 1'b0, acc);
    n_cmp++; if (acc !== 1'b0) begin n_err++; $display("FAIL single_midframe: accept fs %b want 0", acc); end
    wait_commit();
    step();
    n_cmp++; if (commit_pulse !== 1'b0 || rect_all !== m_rect) begin n_err++; $display("FAIL single_after: pulse %b rect %h want 0 %h", commit_pulse, rect_all, m_rect); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic [67:0] c0, c1;
    logic prev;
    c0 = rand_cmd(); c1 = rand_cmd();
    prev = m_lg;
    for (int i = 0; i < 4; i++) begin
      grant_accept(1'b1, 1'b1, c0, c1, i == 3, 1'b0, acc);
      n_cmp++; if (last_grant !== ~prev) begin n_err++; $display("FAIL rr_alternate: got %b want %b", last_grant, ~prev); end
      prev = last_grant;
      wait_commit();
    end
    step();
  endtask

  task automatic test_fs_collision();
    bit acc;
    for (int k = 0; k < 2 * F && (cyc % F) != F - 1; k++) step();
    grant_accept(1'b0, 1'b1, '0, rand_cmd(), 1'b1, 1'b0, acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL collision_align: accept fs %b want 1", acc); end
    wait_commit();
    step();
  endtask

  task automatic test_vs_hold();
    bit acc;
    vs_en = 1'b0;
    step(); step();
    grant_accept(1'b0, 1'b1, '0, rand_cmd(), 1'b1, 1'b0, acc);
    for (int k = 0; k < 3 * F; k++) begin
      step();
      n_cmp++; if (pending !== 1'b1 || commit_pulse !== 1'b0 || rect_all !== m_rect) begin
        n_err++; $display("FAIL vs_hold: pending %b pulse %b rect %h want 1 0 %h", pending, commit_pulse, rect_all, m_rect);
      end
    end
    vs_en = 1'b1;
    wait_commit();
    step();
  endtask

  task automatic test_random();
    bit acc;
    int p;
    for (int i = 0; i < 12; i++) begin
      p = $urandom_range(0, 2);
      repeat ($urandom_range(0, F)) step();
      grant_accept(p != 1, p != 0, rand_cmd(), rand_cmd(), 1'b1, 1'b0, acc);
      wait_commit();
    end
    step();
  endtask

  task automatic test_reset_pending();
    bit acc;
    grant_accept(1'b1, 1'b0, rand_cmd(), '0, 1'b1, 1'b0, acc);
    step();
    reset = 1'b0;
    step();
    m_rect = DEF; m_lg = 1'b1;
    n_cmp++; if (rect_all !== DEF) begin n_err++; $display("FAIL rst_pend_rect: got %h want %h", rect_all, DEF); end
    n_cmp++; if ({pending, commit_pulse, last_grant} !== 3'b001) begin n_err++; $display("FAIL rst_pend_flags: got %b want 001", {pending, commit_pulse, last_grant}); end
    reset = 1'b1;
    for (int k = 0; k < 2 * F; k++) begin
      step();
      n_cmp++; if (commit_pulse !== 1'b0 || pending !== 1'b0 || rect_all !== DEF) begin
        n_err++; $display("FAIL rst_no_commit: pulse %b pending %b rect %h want 0 0 %h", commit_pulse, pending, rect_all, DEF);
      end
    end
  endtask

  task automatic test_check();
    bit acc;
    logic [67:0] bad;
    bad = {11'd50, 11'd10, 11'd40, 11'd20, 24'h123456};
`ifdef VGA_RECT_CHECK_EN
    grant_accept(1'b1, 1'b0, bad, '0, 1'b1, 1'b1, acc);
    step();
    n_cmp++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL cmd_err_width: got %b want 0", cmd_err); end
    for (int k = 0; k < 2 * F; k++) begin
      step();
      n_cmp++; if (pending !== 1'b0 || commit_pulse !== 1'b0 || rect_all !== m_rect) begin
        n_err++; $display("FAIL reject_hold: pending %b pulse %b rect %h want 0 0 %h", pending, commit_pulse, rect_all, m_rect);
      end
    end
    grant_accept(1'b1, 1'b1, rand_cmd(), rand_cmd(), 1'b1, 1'b0, acc);
    wait_commit();
`else
    grant_accept(1'b1, 1'b0, bad, '0, 1'b1, 1'b0, acc);
    wait_commit();
    n_cmp++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL cmd_err_tied: got %b want 0", cmd_err); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_single();
    test_back_to_back();
    test_fs_collision();
    test_vs_hold();
    test_random();
    test_reset_pending();
    test_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
